// File: rtl/layer_stream_sequencer_pkg.sv
// Shared types for the layer stream sequencer: FSM state encoding and counter width.
package layer_stream_sequencer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } lseq_state_e;

    localparam int LSEQ_CNT_W = 16;

endpackage

// File: rtl/frame_buffer_reg.sv
// NN x dataWidth frame register that loads from one of two sources and carries a valid bit.
module frame_buffer_reg
    import layer_stream_sequencer_pkg::*;
#(
    parameter int NN        = 30,
    parameter int dataWidth = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic                    clear_i,
    input  logic                    sel_i,
    input  logic [NN*dataWidth-1:0] data_a_i,
    input  logic [NN*dataWidth-1:0] data_b_i,
    output logic [NN*dataWidth-1:0] data_o,
    output logic                    valid_o
);

    logic [NN*dataWidth-1:0] data_q, data_d;
    logic                    valid_q, valid_d;

    // A load in the same cycle as a clear keeps the buffer valid with the new frame.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = sel_i ? data_b_i : data_a_i;
            valid_d = 1'b1;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/layer_stream_sequencer.sv
// Captures a fully-parallel layer output frame and replays it serially, neuron 0 first.
// Optional LAYER_SEQ_OVR_CNT_EN adds a saturating ovr_count of dropped frames.
module layer_stream_sequencer
    import layer_stream_sequencer_pkg::*;
#(
    parameter int NN        = 30,
    parameter int dataWidth = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           o_valid,
    input  logic [NN*dataWidth-1:0] x_out,
    input  logic                    clr_err,
    output logic                    x_valid,
    output logic [dataWidth-1:0]    x_in,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    overrun,
    output logic                    lane_err
`ifdef LAYER_SEQ_OVR_CNT_EN
    ,
    output logic [LSEQ_CNT_W-1:0]   ovr_count
`endif
);

    localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;

    lseq_state_e             state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    x_valid_q, x_valid_d;
    logic [dataWidth-1:0]    x_in_q, x_in_d;
    logic                    busy_q, busy_d;
    logic                    frame_done_q, frame_done_d;
    logic                    overrun_q, overrun_d;
    logic                    lane_err_q, lane_err_d;

    logic                    capture, partial, is_last, ovr_set;
    logic                    act_load, act_from_pend, act_clear;
    logic                    pend_load, pend_clear;
    logic [NN*dataWidth-1:0] act_frame, pend_frame;
    logic                    act_v, pend_v;
    logic [dataWidth-1:0]    elem;

    assign capture = &o_valid;
    assign partial = (|o_valid) & ~capture;
    assign is_last = (idx_q == IDX_W'(NN - 1));

    frame_buffer_reg #(.NN(NN), .dataWidth(dataWidth)) u_active (
        .clk      (clk),
        .rst      (rst),
        .load_i   (act_load),
        .clear_i  (act_clear),
        .sel_i    (act_from_pend),
        .data_a_i (x_out),
        .data_b_i (pend_frame),
        .data_o   (act_frame),
        .valid_o  (act_v)
    );

    frame_buffer_reg #(.NN(NN), .dataWidth(dataWidth)) u_pending (
        .clk      (clk),
        .rst      (rst),
        .load_i   (pend_load),
        .clear_i  (pend_clear),
        .sel_i    (1'b0),
        .data_a_i (x_out),
        .data_b_i (x_out),
        .data_o   (pend_frame),
        .valid_o  (pend_v)
    );

    always_comb begin
        elem = '0;
        for (int k = 0; k < NN; k++) begin
            if (idx_q == IDX_W'(k)) begin
                elem = act_frame[k*dataWidth +: dataWidth];
            end
        end
    end

    // On the last element the pending frame takes priority; a frame arriving then refills pending.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        x_valid_d     = 1'b0;
        x_in_d        = x_in_q;
        frame_done_d  = 1'b0;
        act_load      = 1'b0;
        act_from_pend = 1'b0;
        act_clear     = 1'b0;
        pend_load     = 1'b0;
        pend_clear    = 1'b0;
        ovr_set       = 1'b0;

        case (state_q)
            IDLE: begin
                if (capture) begin
                    act_load = 1'b1;
                    idx_d    = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (act_v) begin
                    x_valid_d = 1'b1;
                    x_in_d    = elem;
                    if (is_last) begin
                        frame_done_d = 1'b1;
                        idx_d        = '0;
                        if (pend_v) begin
                            act_load      = 1'b1;
                            act_from_pend = 1'b1;
                            pend_load     = capture;
                            pend_clear    = 1'b1;
                        end else if (capture) begin
                            act_load = 1'b1;
                        end else begin
                            act_clear = 1'b1;
                            state_d   = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        if (capture) begin
                            if (!pend_v) begin
                                pend_load = 1'b1;
                            end else begin
                                ovr_set = 1'b1;
                            end
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d     = (state_q == SEND) | pend_v;
        overrun_d  = ovr_set | (overrun_q & ~clr_err);
        lane_err_d = partial | (lane_err_q & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            x_valid_q    <= 1'b0;
            x_in_q       <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            lane_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            x_valid_q    <= x_valid_d;
            x_in_q       <= x_in_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            lane_err_q   <= lane_err_d;
        end
    end

`ifdef LAYER_SEQ_OVR_CNT_EN
    logic [LSEQ_CNT_W-1:0] cnt_q, cnt_d;

    // A drop in the same cycle as clr_err still counts, matching the sticky flag.
    always_comb begin
        cnt_d = clr_err ? '0 : cnt_q;
        if (ovr_set && (cnt_d != '1)) begin
            cnt_d = cnt_d + LSEQ_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ovr_count = cnt_q;
`endif

    assign x_valid    = x_valid_q;
    assign x_in       = x_in_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;
    assign lane_err   = lane_err_q;

endmodule

// File: tb/tb_layer_stream_sequencer.sv
// Table-driven bench for layer_stream_sequencer with NN=10; each row is one clock of inputs and expected outputs.
module tb_layer_stream_sequencer;

    localparam int NN = 10;
    localparam int DW = 16;
    localparam logic [NN-1:0] ALL = 10'h3FF;

    logic               clk = 1'b0;
    logic               rst;
    logic [NN-1:0]      o_valid;
    logic [NN*DW-1:0]   x_out;
    logic               clr_err;
    logic               x_valid;
    logic [DW-1:0]      x_in;
    logic               busy;
    logic               frame_done;
    logic               overrun;
    logic               lane_err;
`ifdef LAYER_SEQ_OVR_CNT_EN
    logic [15:0]        ovr_count;
`endif

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic          rst;
        logic          clr;
        logic [NN-1:0] ov;
        logic [15:0]   base;
        logic          ev;
        logic [15:0]   ein;
        logic          edone;
        logic          ebusy;
        logic          eovr;
        logic          elane;
        logic [15:0]   ecnt;
        int            tag;
    } vec_t;

    vec_t vecs[$];

    layer_stream_sequencer #(.NN(NN), .dataWidth(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .o_valid    (o_valid),
        .x_out      (x_out),
        .clr_err    (clr_err),
        .x_valid    (x_valid),
        .x_in       (x_in),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun),
        .lane_err   (lane_err)
`ifdef LAYER_SEQ_OVR_CNT_EN
        ,
        .ovr_count  (ovr_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic addRow(input logic r, input logic c, input logic [NN-1:0] ov, input logic [15:0] base,
                          input logic ev, input logic [15:0] ein, input logic ed, input logic eb,
                          input logic eo, input logic el, input logic [15:0] ec, input int tag);
        vec_t v;
        v.rst = r; v.clr = c; v.ov = ov; v.base = base;
        v.ev = ev; v.ein = ein; v.edone = ed; v.ebusy = eb;
        v.eovr = eo; v.elane = el; v.ecnt = ec; v.tag = tag;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        rst     = v.rst;
        clr_err = v.clr;
        o_valid = v.ov;
        for (int k = 0; k < NN; k++) begin
            x_out[k*DW +: DW] = v.base + 16'(k + 1);
        end
    endtask

    task automatic cmp(input string name, input int row, input int tag, input logic [15:0] got, input logic [15:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s row %0d scenario %0d: got %h want %h", name, row, tag, got, want);
        end
    endtask

    task automatic checkOutput(input vec_t v, input int row);
        cmp("x_valid",    row, v.tag, 16'(x_valid),    16'(v.ev));
        cmp("x_in",       row, v.tag, x_in,            v.ein);
        cmp("frame_done", row, v.tag, 16'(frame_done), 16'(v.edone));
        cmp("busy",       row, v.tag, 16'(busy),       16'(v.ebusy));
        cmp("overrun",    row, v.tag, 16'(overrun),    16'(v.eovr));
        cmp("lane_err",   row, v.tag, 16'(lane_err),   16'(v.elane));
`ifdef LAYER_SEQ_OVR_CNT_EN
        cmp("ovr_count",  row, v.tag, ovr_count,       v.ecnt);
`endif
    endtask

    task automatic fillTable();
        logic [15:0] e;
        // reset state
        addRow(1, 0, 10'h0, 16'h0, 0, 16'h0, 0, 0, 0, 0, 16'd0, 0);
        addRow(1, 0, 10'h0, 16'h0, 0, 16'h0, 0, 0, 0, 0, 16'd0, 0);

        // single frame 1..10, busy falls one cycle after the last element
        addRow(0, 0, ALL, 16'h0, 0, 16'h0, 0, 0, 0, 0, 16'd0, 1);
        for (int k = 1; k <= 10; k++)
            addRow(0, 0, 10'h0, 16'h0, 1, 16'(k), (k == 10), 1, 0, 0, 16'd0, 1);
        addRow(0, 0, 10'h0, 16'h0, 0, 16'h000A, 0, 0, 0, 0, 16'd0, 1);
        addRow(0, 0, 10'h0, 16'h0, 0, 16'h000A, 0, 0, 0, 0, 16'd0, 1);

        // second frame at T+3 goes to pending and follows with no bubble
        addRow(0, 0, ALL, 16'h0, 0, 16'h000A, 0, 0, 0, 0, 16'd0, 2);
        for (int k = 1; k <= 20; k++) begin
            e = (k <= 10) ? 16'(k) : 16'(16'h10 + k - 10);
            addRow(0, 0, (k == 3) ? ALL : 10'h0, 16'h10, 1, e, (k == 10 || k == 20), 1, 0, 0, 16'd0, 2);
        end
        addRow(0, 0, 10'h0, 16'h0, 0, 16'h001A, 0, 0, 0, 0, 16'd0, 2);

        // frames at T, T+2, T+4: third dropped, first two intact, then clr_err
        addRow(0, 0, ALL, 16'h0, 0, 16'h001A, 0, 0, 0, 0, 16'd0, 3);
        for (int k = 1; k <= 20; k++) begin
            e = (k <= 10) ? 16'(k) : 16'(16'h10 + k - 10);
            addRow(0, 0, (k == 2 || k == 4) ? ALL : 10'h0, (k == 4) ? 16'h20 : 16'h10,
                   1, e, (k == 10 || k == 20), 1, (k >= 4), 0, (k >= 4) ? 16'd1 : 16'd0, 3);
        end
        addRow(0, 0, 10'h0, 16'h0, 0, 16'h001A, 0, 0, 1, 0, 16'd1, 3);
        addRow(0, 1, 10'h0, 16'h0, 0, 16'h001A, 0, 0, 0, 0, 16'd0, 3);

        // new frame on the last-element edge with pending full: nothing dropped
        addRow(0, 0, ALL, 16'h0, 0, 16'h001A, 0, 0, 0, 0, 16'd0, 4);
        for (int k = 1; k <= 30; k++) begin
            e = (k <= 10) ? 16'(k) : (k <= 20) ? 16'(16'h10 + k - 10) : 16'(16'h20 + k - 20);
            addRow(0, 0, (k == 2 || k == 10) ? ALL : 10'h0, (k == 10) ? 16'h20 : 16'h10,
                   1, e, (k % 10 == 0), 1, 0, 0, 16'd0, 4);
        end
        addRow(0, 0, 10'h0, 16'h0, 0, 16'h002A, 0, 0, 0, 0, 16'd0, 4);

        // partial valid sets lane_err without capture; set beats clear
        addRow(0, 0, 10'h00F, 16'h0, 0, 16'h002A, 0, 0, 0, 1, 16'd0, 5);
        addRow(0, 0, 10'h000, 16'h0, 0, 16'h002A, 0, 0, 0, 1, 16'd0, 5);
        addRow(0, 1, 10'h000, 16'h0, 0, 16'h002A, 0, 0, 0, 0, 16'd0, 5);
        addRow(0, 1, 10'h00F, 16'h0, 0, 16'h002A, 0, 0, 0, 1, 16'd0, 5);
        addRow(0, 0, 10'h3FE, 16'h0, 0, 16'h002A, 0, 0, 0, 1, 16'd0, 5);
        addRow(0, 1, 10'h000, 16'h0, 0, 16'h002A, 0, 0, 0, 0, 16'd0, 5);
        addRow(0, 0, 10'h000, 16'h0, 0, 16'h002A, 0, 0, 0, 0, 16'd0, 5);

        // reset while element 5 is on the bus with a frame pending
        addRow(0, 0, ALL, 16'h0, 0, 16'h002A, 0, 0, 0, 0, 16'd0, 6);
        for (int k = 1; k <= 5; k++)
            addRow(0, 0, (k == 2) ? ALL : 10'h0, 16'h10, 1, 16'(k), 0, 1, 0, 0, 16'd0, 6);
        addRow(1, 0, 10'h0, 16'h0, 0, 16'h0, 0, 0, 0, 0, 16'd0, 6);
        for (int k = 0; k < 12; k++)
            addRow(0, 0, 10'h0, 16'h0, 0, 16'h0, 0, 0, 0, 0, 16'd0, 6);
    endtask

    initial begin
        rst     = 1'b1;
        clr_err = 1'b0;
        o_valid = '0;
        x_out   = '0;
        fillTable();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput(vecs[i], i);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
